// File: rtl/hit_count_display.sv
// Purpose: count 1101-detector hits in 4-digit BCD, keep a 4-bit serial history, scan both onto a 4-digit 7-seg display.
// Latency: counter/history update 1 clk after an accepted strobe edge; display registers load every clk from current state.
// Backpressure: none; every rising edge of bit_stb is accepted, a held strobe yields one event.
//
// Ports:
//   clk, rst      system clock; asynchronous active-low reset
//   bit_stb       serial step strobe (rising edge = one event)
//   bit_in        serial bit, sampled on an event
//   hit_in        detector flag, sampled on an event (increments the count)
//   clr           synchronous clear of count, history and ovf (wins over an event)
//   mode          display select: 0 = count, 1 = history
//   bcd_count     {thousands, hundreds, tens, units}
//   history       last four accepted bits, bit0 newest
//   ovf           sticky: count passed 9999
//   seg, an, dp   active-low segment {g..a}, digit enables (an[0] rightmost), decimal point

module hit_count_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          WRAP        = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_stb,
    input  logic        bit_in,
    input  logic        hit_in,
    input  logic        clr,
    input  logic        mode,
    output logic [15:0] bcd_count,
    output logic [3:0]  history,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int unsigned       SCAN_W    = $clog2(REFRESH_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Strobe edge detection. stb_d resets high so a strobe that is already
    // asserted when reset releases is not mistaken for a new edge.
    // ------------------------------------------------------------------
    logic stb_d;
    logic bit_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_d <= 1'b1;
        end else begin
            stb_d <= bit_stb;
        end
    end

    assign bit_evt = bit_stb & ~stb_d;

    // ------------------------------------------------------------------
    // BCD increment with ripple carry. Any digit at 9 (or an illegal code
    // above 9) rolls to 0 and carries, so no digit can hold a value > 9.
    // ------------------------------------------------------------------
    logic [15:0] count_inc;
    logic        inc_carry;
    logic        count_max;

    always_comb begin
        count_inc = bcd_count;
        inc_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inc_carry) begin
                if (bcd_count[i*4 +: 4] >= 4'd9) begin
                    count_inc[i*4 +: 4] = 4'd0;
                end else begin
                    count_inc[i*4 +: 4] = bcd_count[i*4 +: 4] + 4'd1;
                    inc_carry           = 1'b0;
                end
            end
        end
    end

    assign count_max = (bcd_count == 16'h9999);

    // ------------------------------------------------------------------
    // Count, history and overflow state. clr discards a coincident event.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_count <= 16'h0000;
            history   <= 4'h0;
            ovf       <= 1'b0;
        end else if (clr) begin
            bcd_count <= 16'h0000;
            history   <= 4'h0;
            ovf       <= 1'b0;
        end else if (bit_evt) begin
            history <= {history[2:0], bit_in};
            if (hit_in) begin
                if (count_max) begin
                    ovf       <= 1'b1;
                    bcd_count <= WRAP ? 16'h0000 : 16'h9999;
                end else begin
                    bcd_count <= count_inc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan timing: one digit slot every REFRESH_DIV clocks.
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next display word. Leading-zero blanking looks at every digit above
    // the one being shown; the units digit is never blanked.
    // ------------------------------------------------------------------
    logic [3:0] cur_digit;
    logic       lead_blank;
    logic [6:0] seg_nxt;
    logic [3:0] an_nxt;
    logic       dp_nxt;

    always_comb begin
        cur_digit  = bcd_count[{digit_idx, 2'b00} +: 4];
        lead_blank = 1'b0;
        case (digit_idx)
            2'd3:    lead_blank = (bcd_count[15:12] == 4'h0);
            2'd2:    lead_blank = (bcd_count[15:8]  == 8'h00);
            2'd1:    lead_blank = (bcd_count[15:4]  == 12'h000);
            default: lead_blank = 1'b0;
        endcase

        if (mode) begin
            seg_nxt = history[digit_idx] ? SEG_ONE : SEG_ZERO;
        end else if (lead_blank) begin
            seg_nxt = SEG_BLANK;
        end else begin
            seg_nxt = seg_decode(cur_digit);
        end

        an_nxt = ~(4'b0001 << digit_idx);
        // Decimal point on the leftmost digit flags an overflowed count.
        dp_nxt = ~((digit_idx == 2'd3) & ~mode & ovf);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_hit_count_display.sv
module tb_hit_count_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, bit_stb, bit_in, hit_in, clr, mode;

    logic [15:0] bcd_w, bcd_s;
    logic [3:0]  hist_w, hist_s, an_w, an_s;
    logic        ovf_w, ovf_s, dp_w, dp_s;
    logic [6:0]  seg_w, seg_s;

    hit_count_display #(.REFRESH_DIV(4), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .bit_stb(bit_stb), .bit_in(bit_in), .hit_in(hit_in),
        .clr(clr), .mode(mode), .bcd_count(bcd_w), .history(hist_w), .ovf(ovf_w),
        .seg(seg_w), .an(an_w), .dp(dp_w)
    );

    hit_count_display #(.REFRESH_DIV(4), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .bit_stb(bit_stb), .bit_in(bit_in), .hit_in(hit_in),
        .clr(clr), .mode(mode), .bcd_count(bcd_s), .history(hist_s), .ovf(ovf_s),
        .seg(seg_s), .an(an_s), .dp(dp_s)
    );

    typedef enum int {
        S_BCD, S_HIST, S_OVF, S_SEG, S_AN, S_DP,
        S_BCD_SAT, S_HIST_SAT, S_OVF_SAT, S_SEG_SAT, S_AN_SAT, S_DP_SAT
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [15:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [15:0] observe(input sig_e s);
        case (s)
            S_BCD:      return bcd_w;
            S_HIST:     return {12'h0, hist_w};
            S_OVF:      return {15'h0, ovf_w};
            S_SEG:      return {9'h0, seg_w};
            S_AN:       return {12'h0, an_w};
            S_DP:       return {15'h0, dp_w};
            S_BCD_SAT:  return bcd_s;
            S_HIST_SAT: return {12'h0, hist_s};
            S_OVF_SAT:  return {15'h0, ovf_s};
            S_SEG_SAT:  return {9'h0, seg_s};
            S_AN_SAT:   return {12'h0, an_s};
            default:    return {15'h0, dp_s};
        endcase
    endfunction

    task automatic expect_sig(input string name, input sig_e s, input logic [15:0] e);
        chk_t c;
        c.name = name;
        c.sig  = s;
        c.exp  = e;
        sb_q.push_back(c);
    endtask

    // Monitor: drains the scoreboard just after each falling edge, well
    // clear of the rising edge where the DUT updates.
    initial begin
        chk_t        c;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            #1;
            while (sb_q.size() > 0) begin
                c   = sb_q.pop_front();
                act = observe(c.sig);
                tests++;
                if (act !== c.exp) begin
                    fails++;
                    $display("FAIL %s: actual=%h required=%h (t=%0t)", c.name, act, c.exp, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // One strobe: high for len cycles, then low for one cycle. Called and
    // returns on a falling edge, with the update already visible.
    task automatic pulse(input logic b, input logic h, input int len);
        bit_stb = 1'b1;
        bit_in  = b;
        hit_in  = h;
        repeat (len) @(negedge clk);
        bit_stb = 1'b0;
        hit_in  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_digit(input logic [3:0] target);
        int n;
        n = 0;
        while (an_w !== target && n < 16) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (an_w !== target) begin
            fails++;
            $display("FAIL wait_digit: an=%b never reached required=%b", an_w, target);
        end
    endtask

    logic [3:0] an_tab [4];

    initial begin
        an_tab[0] = 4'b1110;
        an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011;
        an_tab[3] = 4'b0111;

        rst = 1'b0; bit_stb = 1'b0; bit_in = 1'b0; hit_in = 1'b0; clr = 1'b0; mode = 1'b0;
        repeat (3) @(negedge clk);
        expect_sig("rst_bcd",  S_BCD,  16'h0000);
        expect_sig("rst_hist", S_HIST, 16'h0000);
        expect_sig("rst_ovf",  S_OVF,  16'h0000);
        expect_sig("rst_seg",  S_SEG,  {9'h0, SEG_BLANK});
        expect_sig("rst_an",   S_AN,   16'h000F);
        expect_sig("rst_dp",   S_DP,   16'h0001);
        @(negedge clk);
        rst = 1'b1;

        // Scan: each digit held for 4 clocks, digit 0 shows '0', others blank.
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            expect_sig("scan_an_first", S_AN, {12'h0, an_tab[s]});
            expect_sig("scan_seg", S_SEG, {9'h0, (s == 0) ? SEG_0 : SEG_BLANK});
            expect_sig("scan_dp", S_DP, 16'h0001);
            repeat (3) @(negedge clk);
            expect_sig("scan_an_last", S_AN, {12'h0, an_tab[s]});
        end

        // Three short strobes plus one held strobe: four events.
        repeat (3) pulse(1'b1, 1'b1, 1);
        pulse(1'b1, 1'b1, 6);
        expect_sig("cnt4_bcd",  S_BCD,     16'h0004);
        expect_sig("cnt4_hist", S_HIST,    16'h000F);
        expect_sig("cnt4_sat",  S_BCD_SAT, 16'h0004);

        // hit without an event is ignored
        hit_in = 1'b1;
        repeat (4) @(negedge clk);
        hit_in = 1'b0;
        expect_sig("hit_noevt", S_BCD, 16'h0004);

        wait_digit(4'b1110);
        expect_sig("cnt4_seg_d0", S_SEG, {9'h0, SEG_4});
        wait_digit(4'b1101);
        expect_sig("cnt4_seg_d1", S_SEG, {9'h0, SEG_BLANK});

        repeat (5) pulse(1'b1, 1'b1, 1);
        expect_sig("cnt9_bcd", S_BCD, 16'h0009);
        pulse(1'b0, 1'b1, 1);
        expect_sig("cnt10_bcd",  S_BCD,  16'h0010);
        expect_sig("cnt10_hist", S_HIST, 16'h000E);
        wait_digit(4'b1101);
        expect_sig("cnt10_seg_d1", S_SEG, {9'h0, SEG_1});
        wait_digit(4'b1110);
        expect_sig("cnt10_seg_d0", S_SEG, {9'h0, SEG_0});
        wait_digit(4'b1011);
        expect_sig("cnt10_seg_d2", S_SEG, {9'h0, SEG_BLANK});

        // Run up to 9999.
        repeat (9989) pulse(1'b0, 1'b1, 1);
        expect_sig("max_bcd",     S_BCD,     16'h9999);
        expect_sig("max_ovf",     S_OVF,     16'h0000);
        expect_sig("max_bcd_sat", S_BCD_SAT, 16'h9999);
        expect_sig("max_ovf_sat", S_OVF_SAT, 16'h0000);

        pulse(1'b0, 1'b1, 1);
        expect_sig("wrap_bcd",    S_BCD,     16'h0000);
        expect_sig("wrap_ovf",    S_OVF,     16'h0001);
        expect_sig("sat_bcd",     S_BCD_SAT, 16'h9999);
        expect_sig("sat_ovf",     S_OVF_SAT, 16'h0001);

        wait_digit(4'b0111);
        expect_sig("wrap_dp_d3",  S_DP,      16'h0000);
        expect_sig("wrap_seg_d3", S_SEG,     {9'h0, SEG_BLANK});
        expect_sig("sat_an_d3",   S_AN_SAT,  16'h0007);
        expect_sig("sat_seg_d3",  S_SEG_SAT, {9'h0, SEG_9});
        expect_sig("sat_dp_d3",   S_DP_SAT,  16'h0000);
        wait_digit(4'b1110);
        expect_sig("wrap_dp_d0",  S_DP,      16'h0001);
        expect_sig("wrap_seg_d0", S_SEG,     {9'h0, SEG_0});

        // ovf is sticky across further counting; saturated count holds.
        repeat (5) pulse(1'b1, 1'b1, 1);
        expect_sig("c5_bcd",     S_BCD,     16'h0005);
        expect_sig("c5_ovf",     S_OVF,     16'h0001);
        expect_sig("c5_bcd_sat", S_BCD_SAT, 16'h9999);

        // History mode suppresses the overflow decimal point.
        mode = 1'b1;
        @(negedge clk);
        wait_digit(4'b0111);
        expect_sig("m1_dp_d3",  S_DP,  16'h0001);
        expect_sig("m1_seg_d3", S_SEG, {9'h0, SEG_1});
        mode = 1'b0;
        @(negedge clk);

        // clr together with a rising strobe carrying a hit: clr wins.
        clr = 1'b1; bit_stb = 1'b1; bit_in = 1'b1; hit_in = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        expect_sig("clr_bcd",     S_BCD,     16'h0000);
        expect_sig("clr_hist",    S_HIST,    16'h0000);
        expect_sig("clr_ovf",     S_OVF,     16'h0000);
        expect_sig("clr_bcd_sat", S_BCD_SAT, 16'h0000);
        expect_sig("clr_ovf_sat", S_OVF_SAT, 16'h0000);
        @(negedge clk);
        expect_sig("clr_held_bcd", S_BCD, 16'h0000);
        bit_stb = 1'b0; hit_in = 1'b0;
        @(negedge clk);

        // History 1,1,0,1 shown in mode 1.
        pulse(1'b1, 1'b0, 1);
        pulse(1'b1, 1'b0, 1);
        pulse(1'b0, 1'b0, 1);
        pulse(1'b1, 1'b0, 1);
        expect_sig("h_hist",     S_HIST,     16'h000D);
        expect_sig("h_hist_sat", S_HIST_SAT, 16'h000D);
        expect_sig("h_bcd",      S_BCD,      16'h0000);
        mode = 1'b1;
        @(negedge clk);
        wait_digit(4'b0111);
        expect_sig("h_seg_d3", S_SEG, {9'h0, SEG_1});
        wait_digit(4'b1011);
        expect_sig("h_seg_d2", S_SEG, {9'h0, SEG_1});
        wait_digit(4'b1101);
        expect_sig("h_seg_d1", S_SEG, {9'h0, SEG_0});
        wait_digit(4'b1110);
        expect_sig("h_seg_d0", S_SEG, {9'h0, SEG_1});
        mode = 1'b0;
        @(negedge clk);

        // Reset in the middle of a strobe at count 0042.
        repeat (42) pulse(1'b0, 1'b1, 1);
        expect_sig("c42_bcd", S_BCD, 16'h0042);
        @(negedge clk);
        bit_stb = 1'b1; hit_in = 1'b1; rst = 1'b0;
        expect_sig("mrst_bcd",  S_BCD,  16'h0000);
        expect_sig("mrst_hist", S_HIST, 16'h0000);
        expect_sig("mrst_ovf",  S_OVF,  16'h0000);
        expect_sig("mrst_seg",  S_SEG,  {9'h0, SEG_BLANK});
        expect_sig("mrst_an",   S_AN,   16'h000F);
        expect_sig("mrst_dp",   S_DP,   16'h0001);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        expect_sig("held_bcd",     S_BCD,     16'h0000);
        expect_sig("held_bcd_sat", S_BCD_SAT, 16'h0000);
        bit_stb = 1'b0;
        @(negedge clk);
        bit_stb = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        bit_stb = 1'b0; hit_in = 1'b0;
        @(negedge clk);
        expect_sig("redge_bcd",  S_BCD,  16'h0001);
        expect_sig("redge_hist", S_HIST, 16'h0001);

        repeat (2) @(negedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hit_count_display.md
Name: hit_count_display

Overview:
- Downstream consumer of the serial-stream / 1101-detector stage.
- Runs on the board system clock. Accepts one strobe per serial bit advance (the debounced step pulse) together with the serial bit and the detector flag.
- Keeps a 4-digit BCD count of detections and a 4-bit history of the most recent serial bits.
- Drives the board's multiplexed 4-digit active-low 7-segment display with either the count or the history.

Parameters:
REFRESH_DIV, 100000, system-clock cycles per digit scan slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
WRAP, 1, 1: count wraps 9999->0000; 0: count saturates at 9999.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
bit_stb  in  1  serial step strobe, clk-synchronous; one event per rising edge, regardless of pulse length.
bit_in  in  1  serial data bit; sampled on an accepted event.
hit_in  in  1  detector output (1 = 1101 completed on this bit); sampled on an accepted event.
clr  in  1  synchronous clear of count, history and ovf.
mode  in  1  0: display count; 1: display history.
bcd_count  out  16  {thousands, hundreds, tens, units}, 4 bits each, registered.
history  out  4  last four accepted bit_in values; bit0 is newest; registered.
ovf  out  1  sticky flag: count passed 9999.
seg  out  7  {g,f,e,d,c,b,a}, active-low, registered.
an  out  4  digit enables, active-low, an[0] = rightmost digit, registered.
dp  out  1  decimal point, active-low, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - bcd_count=0, history=0, ovf=0.
  - Scan counter and digit index = 0; internal stb_d = 1.
  - seg=7'h7F, an=4'hF, dp=1.
- Event detection:
  - event = bit_stb & ~stb_d, where stb_d is bit_stb registered.
  - A strobe held N cycles produces exactly one event.
  - A strobe already high when reset releases produces no event.
- On an event, bit_in and hit_in are sampled in the same cycle. Updates are visible on the next clk edge (1-cycle latency):
  - history <= {history[2:0], bit_in}, every event.
  - If hit_in=1, bcd_count increments as decimal digits with ripple carry; no digit ever holds a value above 9.
  - At 9999 + hit with WRAP=1: bcd_count becomes 0000 and ovf is set.
  - At 9999 + hit with WRAP=0: bcd_count holds 9999 and ovf is set.
  - ovf stays set until clr or reset.
- clr=1: bcd_count, history and ovf all go to 0 on the next edge. clr has priority over a simultaneous event; that event is discarded entirely.
- hit_in=1 without an event is ignored.
- Display scan:
  - The scan counter runs 0..REFRESH_DIV-1, then returns to 0.
  - At each return to 0, the digit index advances 0->1->2->3->0.
- Output register (loaded every cycle from the current index and data):
  - an = one-hot-low of the index (index 0 -> 4'b1110).
  - mode=0: seg shows BCD digit[index]. Leading zeros in digits 3..1 are blanked (7'h7F); digit 0 always shows.
  - mode=1: digit i shows '0' or '1' from history[i].
  - dp=0 only when index=3, mode=0 and ovf=1; otherwise dp=1.
  - First valid digit is driven on the first clk edge after reset release.
  - A mode change takes effect on the next output register load; no blank cycle.
- Segment codes (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset mid-scan or mid-strobe: everything returns to the reset values immediately; no partial increment survives.

Test Plan:
- Reset, then release with mode=0 and REFRESH_DIV=4 -> bcd_count=16'h0000, ovf=0; an cycles 1110,1101,1011,0111 every 4 clk; digit 0 seg=1000000; digits 1..3 seg=1111111.
- 3 single-cycle strobes with hit_in=1, plus one strobe held 6 cycles with hit_in=1 -> bcd_count=16'h0004; history=4'b1111 when bit_in=1 throughout.
- Preload to 0009 via hits, then 1 hit -> bcd_count=16'h0010. Preload to 9999, then 1 hit:
  - WRAP=1 -> 16'h0000, ovf=1, dp=0 on digit 3.
  - WRAP=0 -> 16'h9999, ovf=1.
- Events with bit_in sequence 1,1,0,1 and mode=1 -> history=4'b1101; scan shows digits 3..0 as 1,1,0,1 (seg 1111001,1111001,1000000,1111001).
- clr asserted in the same cycle as an event with hit_in=1, from count 0005/ovf=1 -> next cycle bcd_count=0, history=0, ovf=0.
- rst pulsed low while strobe is high and the count is 0042 -> all outputs at reset values immediately; after release with strobe still high -> no increment until the next rising edge of bit_stb.
